// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the vector multiply-accumulate engine.
package mac_pkg;

  localparam int unsigned WInDef  = 10;
  localparam int unsigned WAccDef = 20;

  typedef logic signed [WInDef-1:0]   operand_t;
  typedef logic signed [2*WInDef-1:0] prod_t;
  typedef logic signed [WAccDef-1:0]  acc_t;

  // One extra bit so the counter width is never zero (VEC_LEN=1).
  function automatic int unsigned cnt_width(input int unsigned vec_len);
    return $clog2(vec_len) + 1;
  endfunction

  // Bit patterns for the saturation limits; callers truncate to w bits.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed adder with overflow detect; clamps to the signed range when
// MAC_SAT_EN is defined, otherwise wraps.
module mac_sat_add #(
  parameter int unsigned W_ACC = 20
) (
  input  logic signed [W_ACC-1:0] x,
  input  logic signed [W_ACC-1:0] y,
  output logic signed [W_ACC-1:0] sum,
  output logic                    add_ovf
);

`ifdef MAC_SAT_EN
  localparam logic signed [W_ACC-1:0] SatMax = W_ACC'(mac_pkg::sat_max(W_ACC));
  localparam logic signed [W_ACC-1:0] SatMin = W_ACC'(mac_pkg::sat_min(W_ACC));
`endif

  logic signed [W_ACC-1:0] raw;

  always_comb begin
    raw     = x + y;
    // Overflow only when both operands share a sign the result does not.
    add_ovf = (x[W_ACC-1] == y[W_ACC-1]) && (raw[W_ACC-1] != x[W_ACC-1]);
`ifdef MAC_SAT_EN
    sum = add_ovf ? (x[W_ACC-1] ? SatMin : SatMax) : raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/mac_vec_accum.sv
// Pipelined signed MAC producing one dot product per VEC_LEN valid elements.
// Optional MAC_SAT_EN selects saturating accumulation instead of wrap.
module mac_vec_accum
  import mac_pkg::*;
#(
  parameter int unsigned W_IN    = 10,
  parameter int unsigned W_ACC   = 20,
  parameter int unsigned VEC_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_IN-1:0]  a,
  input  logic signed [W_IN-1:0]  b,
  input  logic                    valid_in,
  input  logic                    clear,
  output logic signed [W_ACC-1:0] f,
  output logic                    valid_out,
  output logic                    ovf
);

  localparam int unsigned    CntW    = cnt_width(VEC_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(VEC_LEN - 1);

  if (W_ACC < 2 * W_IN) begin : g_chk_acc
    $error("mac_vec_accum: W_ACC must be at least 2*W_IN");
  end
  if (VEC_LEN < 1) begin : g_chk_len
    $error("mac_vec_accum: VEC_LEN must be at least 1");
  end

  logic signed [W_IN-1:0]   a_r, b_r;
  logic signed [2*W_IN-1:0] prod;
  logic signed [W_ACC-1:0]  acc;
  logic [CntW-1:0]          cnt;
  logic                     v1, v2, ovf_sticky;

  logic signed [W_ACC-1:0]  acc_in, prod_ext, sum;
  logic                     add_ovf, is_first, is_last;

  always_comb begin
    is_first = (cnt == '0);
    is_last  = (cnt == CntLast);
    acc_in   = is_first ? '0 : acc;
    prod_ext = W_ACC'(prod);
  end

  mac_sat_add #(
    .W_ACC (W_ACC)
  ) u_add (
    .x       (acc_in),
    .y       (prod_ext),
    .sum     (sum),
    .add_ovf (add_ovf)
  );

  // S1/S2: operand capture and product; clear drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r  <= '0;
      b_r  <= '0;
      prod <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
    end else begin
      if (valid_in) begin
        a_r <= a;
        b_r <= b;
      end
      if (v1) prod <= (2*W_IN)'(a_r) * (2*W_IN)'(b_r);
      v1 <= valid_in & ~clear;
      v2 <= v1 & ~clear;
    end
  end

  // S3: accumulate, count elements and publish the result on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      f          <= '0;
      ovf        <= 1'b0;
      valid_out  <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (v2) begin
        acc        <= sum;
        cnt        <= is_last ? '0 : cnt + CntW'(1);
        ovf_sticky <= (is_first ? 1'b0 : ovf_sticky) | add_ovf;
        if (is_last) begin
          f         <= sum;
          ovf       <= (is_first ? 1'b0 : ovf_sticky) | add_ovf;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_accum.sv
// Scoreboard bench for mac_vec_accum with directed dot-product vectors.
module tb_mac_vec_accum;

  localparam int unsigned W_IN    = 10;
  localparam int unsigned W_ACC   = 20;
  localparam int unsigned VEC_LEN = 4;

  typedef struct {
    logic signed [W_ACC-1:0] f;
    logic                    ovf;
    int                      edge_n;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [W_IN-1:0]  a, b;
  logic                    valid_in, clear;
  logic signed [W_ACC-1:0] f;
  logic                    valid_out, ovf;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;

  mac_vec_accum #(
    .W_IN    (W_IN),
    .W_ACC   (W_ACC),
    .VEC_LEN (VEC_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .clear     (clear),
    .f         (f),
    .valid_out (valid_out),
    .ovf       (ovf)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid_out: got pulse f=%0d at edge %0d, expected none",
                 f, edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_f", f, e.f);
        check("result_ovf", ovf, e.ovf);
        check("result_edge", edge_cnt, e.edge_n);
      end
    end
  end

  task automatic send(input int av, input int bv, input bit last, input int ef,
                      input bit eo);
    exp_t e;
    a        = W_IN'(av);
    b        = W_IN'(bv);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (last) begin
      e.f      = W_ACC'(ef);
      e.ovf    = eo;
      e.edge_n = edge_cnt + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int sat_f;
`ifdef MAC_SAT_EN
    sat_f = 524287;
`else
    sat_f = 0;
`endif
    reset    = 1'b1;
    a        = '0;
    b        = '0;
    valid_in = 1'b0;
    clear    = 1'b0;
    #2 reset = 1'b0;
    #10;
    check("reset_f", f, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_ovf", ovf, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);

    // 1: back-to-back (3,4)
    for (int i = 0; i < 4; i++) send(3, 4, i == 3, 48, 0);
    idle(3);

    // 2: gapped elements
    send(2, 5, 0, 0, 0);
    idle(1);
    send(-3, 7, 0, 0, 0);
    idle(3);
    send(10, 10, 0, 0, 0);
    idle(2);
    send(-1, -1, 1, 90, 0);
    idle(3);

    // 3: overflow then a clean vector
    for (int i = 0; i < 4; i++) send(-512, -512, i == 3, sat_f, 1);
    for (int i = 0; i < 4; i++) send(1, 1, i == 3, 4, 0);
    idle(3);

    // 4: partial vector flushed by clear (with a discarded valid element)
    check("f_before_clear", f, 4);
    send(7, 7, 0, 0, 0);
    send(7, 7, 0, 0, 0);
    clear    = 1'b1;
    a        = W_IN'(9);
    b        = W_IN'(9);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    idle(3);
    check("f_hold_after_clear", f, 4);
    for (int i = 0; i < 4; i++) send(1, 1, i == 3, 4, 0);
    idle(3);

    // 5: continuous stream spanning two vectors
    for (int i = 1; i <= 8; i++) send(1, i, (i == 4) || (i == 8), (i == 4) ? 10 : 26, 0);
    idle(3);

    // 6: asynchronous reset mid-vector
    check("f_before_reset", f, 26);
    send(2, 2, 0, 0, 0);
    send(2, 2, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_f", f, 0);
    check("async_reset_valid_out", valid_out, 0);
    check("async_reset_ovf", ovf, 0);
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(2, 2, i == 3, 16, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
